// File: rtl/add_chk_pkg.sv
// Shared state type, default parameters and counter helpers for the adder result checker.
package add_chk_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_LATENCY = 1;
  localparam int DEF_NUM_TXN = 16;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == {CNT_W{1'b1}}) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/add_chk_delay.sv
// Fixed-depth valid+payload shift line; an entry written at edge N appears on the outputs
// after edge N+DEPTH-1, so it is consumed at edge N+DEPTH.
module add_chk_delay
  import add_chk_pkg::*;
#(
  parameter int DAT_W = 13,
  parameter int DEPTH = DEF_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic [DAT_W-1:0] i_dat,
  output logic             o_vld,
  output logic [DAT_W-1:0] o_dat
);

  logic [DEPTH-1:0] r_vld;
  logic [DAT_W-1:0] r_dat [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld;
      r_dat[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_dat = r_dat[DEPTH-1];

endmodule

// File: rtl/add_checker.sv
// Checks an adder DUT: issues up to NUM_TXN operand pairs per run, compares each against the
// sum returned LATENCY cycles later, and reports counts plus the first mismatch.
module add_checker
  import add_chk_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int NUM_TXN = DEF_NUM_TXN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   sum,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH:0]   first_err_exp,
  output logic [WIDTH:0]   first_err_got
);

  localparam int   DAT_W = 3 * WIDTH + 1;
  localparam cnt_t LIMIT = cnt_t'(NUM_TXN);

  state_t           r_state;
  cnt_t             r_issue;
  cnt_t             r_txn;
  cnt_t             r_err;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_fv;
  logic [WIDTH-1:0] r_fa;
  logic [WIDTH-1:0] r_fb;
  logic [WIDTH:0]   r_fe;
  logic [WIDTH:0]   r_fg;

  logic             w_accept;
  logic [DAT_W-1:0] w_push_dat;
  logic             w_exit_vld;
  logic [DAT_W-1:0] w_exit_dat;
  logic [WIDTH-1:0] w_exit_a;
  logic [WIDTH-1:0] w_exit_b;
  logic [WIDTH:0]   w_exit_exp;
  logic             w_check;
  logic             w_miss;
  logic             w_last;
  cnt_t             w_err_nxt;

  assign w_accept   = (r_state == ST_RUN) && in_valid && (r_issue < LIMIT);
  assign w_push_dat = {a, b, {1'b0, a} + {1'b0, b}};

  add_chk_delay #(
    .DAT_W (DAT_W),
    .DEPTH (LATENCY)
  ) u_delay (
    .clk   (clk),
    .rst   (rst),
    .i_vld (w_accept),
    .i_dat (w_push_dat),
    .o_vld (w_exit_vld),
    .o_dat (w_exit_dat)
  );

  // Exiting entries outside RUN are simply dropped.
  assign {w_exit_a, w_exit_b, w_exit_exp} = w_exit_dat;
  assign w_check   = (r_state == ST_RUN) && w_exit_vld;
  assign w_miss    = w_check && (sum != w_exit_exp);
  assign w_err_nxt = w_miss ? sat_inc(r_err) : r_err;
  assign w_last    = w_check && ((r_txn + cnt_t'(1)) == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_issue <= '0;
      r_txn   <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fv    <= 1'b0;
      r_fa    <= '0;
      r_fb    <= '0;
      r_fe    <= '0;
      r_fg    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_issue <= '0;
            r_txn   <= '0;
            r_err   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fv    <= 1'b0;
            r_fa    <= '0;
            r_fb    <= '0;
            r_fe    <= '0;
            r_fg    <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) r_issue <= r_issue + cnt_t'(1);
          if (w_check)  r_txn   <= r_txn + cnt_t'(1);
          r_err <= w_err_nxt;
          if (w_miss && !r_fv) begin
            r_fv <= 1'b1;
            r_fa <= w_exit_a;
            r_fb <= w_exit_b;
            r_fe <= w_exit_exp;
            r_fg <= sum;
          end
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign txn_count       = r_txn;
  assign err_count       = r_err;
  assign first_err_valid = r_fv;
  assign first_err_a     = r_fa;
  assign first_err_b     = r_fb;
  assign first_err_exp   = r_fe;
  assign first_err_got   = r_fg;

endmodule

// File: tb/tb_add_checker.sv
// Bench for add_checker: two instances (LATENCY 1 and 3) driven from directed and random
// cycles, checked against a queue-based transaction model.
module tb_add_checker;

  localparam int W   = 4;
  localparam int SW  = W + 1;
  localparam int NUM = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          st_i   [2];
  logic          vld_i  [2];
  logic [W-1:0]  a_i    [2];
  logic [W-1:0]  b_i    [2];
  logic [SW-1:0] s_i    [2];
  logic          busy_o [2];
  logic          done_o [2];
  logic          pass_o [2];
  logic          fv_o   [2];
  logic [7:0]    txn_o  [2];
  logic [7:0]    err_o  [2];
  logic [W-1:0]  fa_o   [2];
  logic [W-1:0]  fb_o   [2];
  logic [SW-1:0] fe_o   [2];
  logic [SW-1:0] fg_o   [2];

  add_checker #(.WIDTH(W), .LATENCY(1), .NUM_TXN(NUM)) u_dut_l1 (
    .clk(clk), .rst(rst), .start(st_i[0]), .in_valid(vld_i[0]), .a(a_i[0]), .b(b_i[0]),
    .sum(s_i[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .txn_count(txn_o[0]), .err_count(err_o[0]), .first_err_valid(fv_o[0]),
    .first_err_a(fa_o[0]), .first_err_b(fb_o[0]), .first_err_exp(fe_o[0]),
    .first_err_got(fg_o[0])
  );

  add_checker #(.WIDTH(W), .LATENCY(3), .NUM_TXN(NUM)) u_dut_l3 (
    .clk(clk), .rst(rst), .start(st_i[1]), .in_valid(vld_i[1]), .a(a_i[1]), .b(b_i[1]),
    .sum(s_i[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .txn_count(txn_o[1]), .err_count(err_o[1]), .first_err_valid(fv_o[1]),
    .first_err_a(fa_o[1]), .first_err_b(fb_o[1]), .first_err_exp(fe_o[1]),
    .first_err_got(fg_o[1])
  );

  typedef struct {
    int a;
    int b;
    int exp;
    int due;
  } ent_t;

  ent_t pend[$];
  int   dsel = 0;
  int   lat  = 1;
  int   t    = 0;
  int   m_busy, m_done, m_txn, m_err, m_iss, m_fv, m_fa, m_fb, m_fe, m_fg;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d, dut=%0d)", tag, got, exp, t, dsel);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    m_busy = 0; m_done = 0; m_txn = 0; m_err = 0; m_iss = 0;
    m_fv = 0; m_fa = 0; m_fb = 0; m_fe = 0; m_fg = 0;
  endtask

  // One clock edge of the transaction-level model.
  task automatic model_edge(input int st, input int v, input int aa, input int bb, input int s);
    int   was_active;
    ent_t e;
    t++;
    was_active = m_busy;
    if (pend.size() > 0 && pend[0].due == t) begin
      e = pend.pop_front();
      if (was_active != 0) begin
        m_txn++;
        if (s != e.exp) begin
          if (m_err < 255) m_err++;
          if (m_fv == 0) begin
            m_fv = 1; m_fa = e.a; m_fb = e.b; m_fe = e.exp; m_fg = s;
          end
        end
        if (m_txn == NUM) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
    if (was_active != 0 && v != 0 && m_iss < NUM) begin
      e.a = aa; e.b = bb; e.exp = aa + bb; e.due = t + lat;
      pend.push_back(e);
      m_iss++;
    end
    if (st != 0 && was_active == 0) begin
      model_clear();
      m_busy = 1;
    end
  endtask

  task automatic check_all();
    chk("busy",      int'(busy_o[dsel]), m_busy);
    chk("done",      int'(done_o[dsel]), m_done);
    chk("pass",      int'(pass_o[dsel]), (m_done != 0 && m_err == 0) ? 1 : 0);
    chk("txn_count", int'(txn_o[dsel]),  m_txn);
    chk("err_count", int'(err_o[dsel]),  m_err);
    chk("first_vld", int'(fv_o[dsel]),   m_fv);
    chk("first_a",   int'(fa_o[dsel]),   m_fa);
    chk("first_b",   int'(fb_o[dsel]),   m_fb);
    chk("first_exp", int'(fe_o[dsel]),   m_fe);
    chk("first_got", int'(fg_o[dsel]),   m_fg);
  endtask

  // fsum < 0 returns the correct sum for whatever is due at the coming edge.
  task automatic cycle(input int st, input int v, input int aa, input int bb, input int fsum);
    int s;
    s = $urandom_range(0, 31);
    if (pend.size() > 0 && pend[0].due == t + 1) s = pend[0].exp;
    if (fsum >= 0) s = fsum;
    st_i[dsel]  = (st != 0);
    vld_i[dsel] = (v != 0);
    a_i[dsel]   = W'(aa);
    b_i[dsel]   = W'(bb);
    s_i[dsel]   = SW'(s);
    @(posedge clk);
    model_edge(st, v, aa, bb, s);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      st_i[k] = 1'b0; vld_i[k] = 1'b0; a_i[k] = '0; b_i[k] = '0; s_i[k] = '0;
    end
    #2 rst = 1'b1;
    #1;
    model_clear();
    chk("rst_busy", int'(busy_o[dsel]), 0);
    chk("rst_done", int'(done_o[dsel]), 0);
    chk("rst_pass", int'(pass_o[dsel]), 0);
    chk("rst_txn",  int'(txn_o[dsel]),  0);
    chk("rst_err",  int'(err_o[dsel]),  0);
    chk("rst_fv",   int'(fv_o[dsel]),   0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic random_run(input int cycles);
    cycle(1, 0, 0, 0, -1);
    for (int i = 0; i < cycles; i++) begin
      cycle(($urandom_range(0, 24) == 0) ? 1 : 0,
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            $urandom_range(0, 15), $urandom_range(0, 15),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : -1);
    end
  endtask

  initial begin
    model_clear();
    for (int k = 0; k < 2; k++) begin
      st_i[k] = 1'b0; vld_i[k] = 1'b0; a_i[k] = '0; b_i[k] = '0; s_i[k] = '0;
    end
    dsel = 0;
    lat  = 1;
    do_reset();

    // Sixteen clean pairs summing to 15.
    cycle(1, 0, 0, 0, -1);
    for (int i = 0; i < 16; i++) cycle(0, 1, i, 15 - i, -1);
    cycle(0, 0, 0, 0, -1);
    chk("clean_done", int'(done_o[0]), 1);
    chk("clean_pass", int'(pass_o[0]), 1);
    chk("clean_txn",  int'(txn_o[0]),  16);
    chk("clean_err",  int'(err_o[0]),  0);

    // Third pair (3+5) answered with 0.
    cycle(1, 0, 0, 0, -1);
    for (int i = 0; i < 16; i++)
      cycle(0, 1, (i == 2) ? 3 : i, (i == 2) ? 5 : i, (i == 3) ? 0 : -1);
    cycle(0, 0, 0, 0, -1);
    chk("bad3_err",  int'(err_o[0]), 1);
    chk("bad3_fa",   int'(fa_o[0]),  3);
    chk("bad3_fb",   int'(fb_o[0]),  5);
    chk("bad3_fexp", int'(fe_o[0]),  8);
    chk("bad3_fgot", int'(fg_o[0]),  0);
    chk("bad3_pass", int'(pass_o[0]), 0);

    // Restart from a failing DONE.
    cycle(1, 0, 0, 0, -1);
    chk("restart_busy", int'(busy_o[0]), 1);
    chk("restart_err",  int'(err_o[0]),  0);
    chk("restart_fv",   int'(fv_o[0]),   0);
    chk("restart_txn",  int'(txn_o[0]),  0);

    // Valid while idle, then 20 pairs: only 16 count.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, i, i, -1);
    cycle(1, 1, 7, 7, -1);
    for (int i = 0; i < 20; i++) cycle(0, 1, $urandom_range(0, 15), $urandom_range(0, 15), -1);
    cycle(0, 0, 0, 0, -1);
    cycle(0, 0, 0, 0, -1);
    chk("excess_txn",  int'(txn_o[0]),  16);
    chk("excess_done", int'(done_o[0]), 1);

    // Reset after the fifth comparison, then a clean run.
    cycle(1, 0, 0, 0, -1);
    for (int i = 0; i < 6; i++) cycle(0, 1, i, 2 * i, -1);
    chk("mid_txn", int'(txn_o[0]), 5);
    do_reset();
    cycle(1, 0, 0, 0, -1);
    chk("post_rst_txn", int'(txn_o[0]), 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 15 - i, i / 2, -1);
    cycle(0, 0, 0, 0, -1);
    chk("post_rst_run_txn",  int'(txn_o[0]),  16);
    chk("post_rst_run_pass", int'(pass_o[0]), 1);

    random_run(300);

    // Three-cycle latency instance.
    do_reset();
    dsel = 1;
    lat  = 3;
    model_clear();
    cycle(1, 0, 0, 0, -1);
    for (int i = 0; i < 16; i++) cycle(0, 1, 15, 15, -1);
    repeat (3) cycle(0, 0, 0, 0, -1);
    chk("l3_txn",  int'(txn_o[1]),  16);
    chk("l3_err",  int'(err_o[1]),  0);
    chk("l3_pass", int'(pass_o[1]), 1);

    cycle(1, 0, 0, 0, -1);
    cycle(0, 1, 15, 15, -1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 30);
    cycle(0, 0, 0, 0, 0);
    chk("l3_early_err",  int'(err_o[1]), 1);
    chk("l3_early_fexp", int'(fe_o[1]),  30);
    chk("l3_early_fgot", int'(fg_o[1]),  0);

    random_run(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/add_checker.md
ADD_CHECKER -- requirements
Module: add_checker

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits.
REQ-002 Parameter LATENCY, default 1, DUT clock cycles from operands to sum; legal range 1..4.
REQ-003 Parameter NUM_TXN, default 16, comparisons per run; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a run.
REQ-007 in_valid  input  1  a/b presented to the DUT this cycle.
REQ-008 a  input  WIDTH  operand A as driven to the DUT.
REQ-009 b  input  WIDTH  operand B as driven to the DUT.
REQ-010 sum  input  WIDTH+1  DUT result.
REQ-011 busy  output  1  high in RUN.
REQ-012 done  output  1  high in DONE.
REQ-013 pass  output  1  high in DONE when err_count is 0.
REQ-014 txn_count  output  8  comparisons completed in the current run.
REQ-015 err_count  output  8  mismatches in the current run; saturates at 255.
REQ-016 first_err_valid  output  1  first-mismatch capture registers hold data.
REQ-017 first_err_a, first_err_b  output  WIDTH each  operands of the first mismatch.
REQ-018 first_err_exp, first_err_got  output  WIDTH+1 each  expected and observed sums of the first mismatch.

Function
REQ-019 FSM states: IDLE, RUN, DONE; reset state is IDLE.
REQ-020 IDLE -> RUN on start; all counters and capture registers clear on the same edge.
REQ-021 RUN -> DONE on the edge where txn_count reaches NUM_TXN.
REQ-022 DONE -> RUN on start, with the same clearing as REQ-020; otherwise DONE holds all results.
REQ-023 start in RUN is ignored.
REQ-024 In RUN, in_valid is accepted while issue count < NUM_TXN; excess in_valid and all in_valid in IDLE/DONE are ignored.
REQ-025 Accepted operands push {a, b, a+b} into a LATENCY-deep delay line; a+b is computed at WIDTH+1 bits with no truncation (15+15=30 at WIDTH=4).
REQ-026 An entry exiting the delay line is compared against sum in that same cycle, so an operand accepted at edge N is checked against sum sampled at edge N+LATENCY.
REQ-027 Each comparison increments txn_count; each mismatch increments err_count, saturating at 255.
REQ-028 The first mismatch of a run loads the capture registers and sets first_err_valid; later mismatches leave them unchanged.
REQ-029 Entries exiting with valid low cause no comparison; gaps in in_valid are legal.
REQ-030 The delay line keeps shifting in DONE and IDLE, but nothing is pushed and exiting entries are discarded.

Reset
REQ-031 rst asserted forces IDLE, clears the delay line, and drives every output to 0 immediately, independent of clk.
REQ-032 rst asserted mid-run discards in-flight entries; the first edge after release sees IDLE.

Structure
REQ-033 Package add_chk_pkg holds the state enum, the default WIDTH/LATENCY/NUM_TXN constants, and the 8-bit count width.
REQ-034 Sub-module add_chk_delay implements the parameterised valid+payload delay line; add_checker instantiates it once.

Verification
REQ-035 Defaults, start, 16 consecutive correct pairs (a=i, b=15-i, sum=15 one cycle later) -> done=1, pass=1, txn_count=16, err_count=0 on the 17th edge after start.
REQ-036 Defaults, sum forced to 0 on the 3rd pair (a=3, b=5) -> err_count=1, first_err_a=3, first_err_b=5, first_err_exp=8, first_err_got=0, pass=0.
REQ-037 LATENCY=3, a=15, b=15, sum=30 three cycles later -> no mismatch; sum=30 at two cycles -> mismatch counted.
REQ-038 in_valid in IDLE, then start with 20 valid pairs -> only 16 compared, txn_count=16, pairs 17-20 ignored.
REQ-039 rst pulse after the 5th comparison -> all outputs 0 at once, IDLE; a new start gives a clean run with txn_count restarting at 0.
REQ-040 Start in DONE after a failing run -> counters and first_err_valid clear, busy=1 on the next edge.
